// File: rtl/trng_ro_entropy_src.sv
`default_nettype none
// ============================================================================
// Module   : trng_ro_entropy_src
// Function : Multi-channel ring-oscillator entropy source with sampler,
//            optional von Neumann debiasing, repetition health test and
//            word packing onto a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
module trng_ro_entropy_src #(
    parameter int NUM_RO        = 4,
    parameter int BASE_STAGES   = 5,
    parameter int WORD_WIDTH    = 32,
    parameter int WARMUP_CYCLES = 256,
    parameter int REP_LIMIT     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  debias_en,
    input  logic [7:0]            sample_div,
    input  logic                  test_en,
    input  logic                  test_bit,
    input  logic                  health_clr,
    output logic [WORD_WIDTH-1:0] rnd_data,
    output logic                  rnd_valid,
    input  logic                  rnd_ready,
    output logic                  health_fail,
    output logic                  busy
);

    localparam int c_cnt_w  = $clog2(WORD_WIDTH);
    localparam int c_warm_w = $clog2(WARMUP_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]  c_last_bit  = c_cnt_w'(WORD_WIDTH - 1);
    localparam logic [c_warm_w-1:0] c_warm_last = c_warm_w'(WARMUP_CYCLES - 1);
    localparam logic [7:0]          c_rep_limit = 8'(REP_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    logic [NUM_RO-1:0]     w_ro;
    logic [NUM_RO-1:0]     r_sync1;
    logic [NUM_RO-1:0]     r_sync2;
    state_t                r_state;
    logic [c_warm_w-1:0]   r_warm;
    logic [7:0]            r_div;
    logic [7:0]            r_rep;
    logic [c_cnt_w-1:0]    r_bitcnt;
    logic [WORD_WIDTH-1:0] r_shift;
    logic                  r_debias;
    logic                  r_pair_have;
    logic                  r_pair_first;
    logic                  r_prev;
    logic                  w_raw;
    logic                  w_strobe;
    logic                  w_accept;
    logic                  w_bit;
    logic                  w_complete;
    logic                  w_fail_set;
    logic [7:0]            w_rep_next;
    logic [WORD_WIDTH-1:0] w_word;

    for (genvar i = 0; i < NUM_RO; i++) begin : g_ch
        localparam int c_stages = BASE_STAGES + 2 * i;
`ifdef SYNTHESIS
        (* keep = "true", dont_touch = "true" *) logic [c_stages-1:0] w_ring;
        assign w_ring[0] = enable & ~w_ring[c_stages-1];
        for (genvar s = 1; s < c_stages; s++) begin : g_stage
            assign w_ring[s] = ~w_ring[s-1];
        end
        assign w_ro[i] = w_ring[c_stages-1];
`else
        // Clocked stand-in: a zero-delay inverter loop never settles in simulation.
        localparam logic [15:0] c_seed = 16'hACE1 ^ 16'(c_stages);
        logic [15:0] r_lfsr;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_lfsr <= c_seed;
            else if (enable)
                r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
        assign w_ro[i] = enable & r_lfsr[0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_ro;
            r_sync2 <= r_sync1;
        end
    end

    assign w_raw      = test_en ? test_bit : ^r_sync2;
    assign w_strobe   = (r_state == ST_RUN) && enable && (r_div >= sample_div);
    assign w_word     = {r_shift[WORD_WIDTH-2:0], w_bit};
    assign w_complete = w_accept && (r_bitcnt == c_last_bit);
    assign w_fail_set = w_strobe && (w_rep_next == c_rep_limit);

    // In debias mode the first bit of an unequal pair is the emitted bit.
    always_comb begin
        w_accept = 1'b0;
        w_bit    = w_raw;
        if (w_strobe) begin
            if (!r_debias) begin
                w_accept = 1'b1;
            end else if (r_pair_have && (r_pair_first != w_raw)) begin
                w_accept = 1'b1;
                w_bit    = r_pair_first;
            end
        end
    end

    always_comb begin
        if ((r_rep == 8'd0) || (w_raw != r_prev))
            w_rep_next = 8'd1;
        else if (r_rep == 8'hFF)
            w_rep_next = r_rep;
        else
            w_rep_next = r_rep + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            busy         <= 1'b0;
            r_warm       <= '0;
            r_div        <= '0;
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_debias     <= 1'b0;
            r_pair_have  <= 1'b0;
            r_pair_first <= 1'b0;
            r_prev       <= 1'b0;
            r_rep        <= '0;
            health_fail  <= 1'b0;
            rnd_data     <= '0;
            rnd_valid    <= 1'b0;
        end else begin
            if (!enable) begin
                r_state     <= ST_IDLE;
                busy        <= 1'b0;
                r_warm      <= '0;
                r_div       <= '0;
                r_bitcnt    <= '0;
                r_shift     <= '0;
                r_pair_have <= 1'b0;
                r_rep       <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state  <= ST_WARMUP;
                        busy     <= 1'b1;
                        r_debias <= debias_en;
                        r_warm   <= '0;
                    end
                    ST_WARMUP: begin
                        if (r_warm == c_warm_last)
                            r_state <= ST_RUN;
                        else
                            r_warm <= r_warm + c_warm_w'(1);
                    end
                    ST_RUN: begin
                        r_div <= w_strobe ? 8'd0 : r_div + 8'd1;
                        if (w_strobe) begin
                            r_prev <= w_raw;
                            r_rep  <= w_rep_next;
                            if (r_debias) begin
                                r_pair_have <= ~r_pair_have;
                                if (!r_pair_have)
                                    r_pair_first <= w_raw;
                            end
                        end
                        if (w_accept) begin
                            r_shift  <= w_word;
                            r_bitcnt <= (r_bitcnt == c_last_bit) ? '0 : r_bitcnt + c_cnt_w'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end

            if (health_clr)
                r_rep <= '0;

            if (w_fail_set)
                health_fail <= 1'b1;
            else if (health_clr)
                health_fail <= 1'b0;

            // A completed word only lands if the output slot is free or being drained.
            if (w_complete && !health_fail && (!rnd_valid || rnd_ready)) begin
                rnd_data  <= w_word;
                rnd_valid <= 1'b1;
            end else if (rnd_valid && rnd_ready) begin
                rnd_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trng_ro_entropy_src.sv
`default_nettype none
// ============================================================================
// Module   : tb_trng_ro_entropy_src
// Function : Self-checking bench for trng_ro_entropy_src against a
//            behavioural reference model driven by injected test bits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trng_ro_entropy_src;

    localparam int WARM = 256;
    localparam int REP  = 32;
    localparam int W    = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable, debias_en, test_en, test_bit, health_clr, rnd_ready;
    logic [7:0]   sample_div;
    logic [W-1:0] rnd_data;
    logic         rnd_valid, health_fail, busy;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int         m_e, m_nbits, m_run, m_strobes, m_words;
    bit         m_debias, m_have, m_first, m_last, m_valid, m_fail, m_busy;
    logic [W-1:0] m_word, m_data;

    trng_ro_entropy_src #(
        .NUM_RO(4), .BASE_STAGES(5), .WORD_WIDTH(W), .WARMUP_CYCLES(WARM), .REP_LIMIT(REP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .debias_en(debias_en),
        .sample_div(sample_div), .test_en(test_en), .test_bit(test_bit),
        .health_clr(health_clr), .rnd_data(rnd_data), .rnd_valid(rnd_valid),
        .rnd_ready(rnd_ready), .health_fail(health_fail), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_e = -1; m_nbits = 0; m_run = 0; m_strobes = 0; m_words = 0;
        m_debias = 0; m_have = 0; m_first = 0; m_last = 0;
        m_valid = 0; m_fail = 0; m_busy = 0; m_word = '0; m_data = '0;
    endtask

    // Strobe k of a run lands sample_div clocks into each (sample_div+1) window after warm-up.
    task automatic model_step();
        bit strobe, emit, b, s, complete, fail_set;
        int d;
        strobe = 0; emit = 0; b = 0; complete = 0; fail_set = 0;
        d = int'(sample_div);
        s = test_bit;
        if (!enable) begin
            m_e = -1; m_nbits = 0; m_word = '0; m_have = 0; m_run = 0; m_strobes = 0; m_words = 0;
        end else begin
            if (m_e < 0) begin
                m_e = 0;
                m_debias = debias_en;
            end else begin
                m_e++;
            end
            if (m_e >= WARM + 1 && ((m_e - WARM - 1) % (d + 1)) == d) strobe = 1;
        end
        if (strobe) begin
            m_strobes++;
            if (m_run == 0 || s != m_last) m_run = 1;
            else if (m_run < 255) m_run++;
            m_last = s;
            fail_set = (m_run == REP);
            if (!m_debias) begin
                emit = 1; b = s;
            end else if (m_have) begin
                m_have = 0;
                if (m_first != s) begin emit = 1; b = m_first; end
            end else begin
                m_have = 1; m_first = s;
            end
            if (emit) begin
                m_word = {m_word[W-2:0], b};
                m_nbits++;
                if (m_nbits == W) begin m_nbits = 0; complete = 1; m_words++; end
            end
        end
        if (complete && !m_fail && (!m_valid || rnd_ready)) begin
            m_data = m_word; m_valid = 1;
        end else if (m_valid && rnd_ready) begin
            m_valid = 0;
        end
        if (fail_set) m_fail = 1;
        else if (health_clr) m_fail = 0;
        if (health_clr) m_run = 0;
        m_busy = (m_e >= 0);
    endtask

    task automatic tick();
        if (!rst_n) model_reset();
        else model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_prep();
        enable = 0; rnd_ready = 1; test_en = 1; test_bit = 0; sample_div = 0;
        health_clr = 1;
        tick();
        health_clr = 0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) tick();
        n_cmp++; if (rnd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rnd_valid); end
        n_cmp++; if (rnd_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", rnd_data); end
        n_cmp++; if (health_fail !== 1'b0) begin n_bad++; $display("FAIL reset_health: got %b want 0", health_fail); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_warmup();
        int first = -1;
        idle_prep();
        debias_en = 0; enable = 1;
        for (int k = 0; k < 300; k++) begin
            test_bit = 1'(m_strobes % 2);
            tick();
            n_cmp++;
            if (rnd_valid !== m_valid || rnd_data !== m_data || health_fail !== m_fail || busy !== m_busy) begin
                n_bad++;
                $display("FAIL warmup_model k=%0d: got v=%b d=%h f=%b b=%b want v=%b d=%h f=%b b=%b",
                         k, rnd_valid, rnd_data, health_fail, busy, m_valid, m_data, m_fail, m_busy);
            end
            if (k == 0) begin
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL warmup_busy: got %b want 1", busy); end
            end
            if (rnd_valid === 1'b1 && first < 0) first = k;
        end
        n_cmp++;
        if (first != WARM + W) begin n_bad++; $display("FAIL warmup_latency: got %0d want %0d", first, WARM + W); end
    endtask

    task automatic test_raw_packing();
        int pat[4] = '{1, 0, 1, 1};
        int rises = 0, last = -1;
        bit pv = 0;
        idle_prep();
        debias_en = 0; enable = 1;
        for (int k = 0; k < 400 && rises < 3; k++) begin
            test_bit = 1'(pat[m_strobes % 4]);
            tick();
            if (rnd_valid === 1'b1 && !pv) begin
                rises++;
                n_cmp++;
                if (rnd_data !== 32'hBBBB_BBBB) begin n_bad++; $display("FAIL raw_word: got %h want bbbbbbbb", rnd_data); end
                if (last >= 0) begin
                    n_cmp++;
                    if (k - last != W) begin n_bad++; $display("FAIL raw_period: got %0d want %0d", k - last, W); end
                end
                last = k;
            end
            pv = rnd_valid;
        end
        n_cmp++;
        if (rises != 3) begin n_bad++; $display("FAIL raw_count: got %0d want 3", rises); end
    endtask

    task automatic test_debias();
        int pat[8] = '{0, 1, 1, 0, 0, 0, 1, 1};
        int first = -1;
        idle_prep();
        debias_en = 1; enable = 1;
        for (int k = 0; k < 500 && first < 0; k++) begin
            if (k == 5) debias_en = 0;
            test_bit = 1'(pat[m_strobes % 8]);
            tick();
            if (rnd_valid === 1'b1) begin
                first = k;
                n_cmp++;
                if (rnd_data !== 32'h5555_5555) begin n_bad++; $display("FAIL debias_word: got %h want 55555555", rnd_data); end
            end
        end
        n_cmp++;
        if (first != WARM + 15 * 8 + 4) begin
            n_bad++; $display("FAIL debias_latency: got %0d want %0d", first, WARM + 15 * 8 + 4);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_first = '0;
        int extra = 0;
        idle_prep();
        debias_en = 0; rnd_ready = 0; enable = 1;
        for (int k = 0; k < 1000 && extra < 3; k++) begin
            test_bit = 1'($urandom_range(0, 1));
            tick();
            if (m_words == 1 && exp_first === '0) exp_first = m_word;
            if (m_words >= 2) extra++;
            n_cmp++;
            if (rnd_valid !== m_valid || rnd_data !== m_data) begin
                n_bad++; $display("FAIL bp_model k=%0d: got v=%b d=%h want v=%b d=%h", k, rnd_valid, rnd_data, m_valid, m_data);
            end
        end
        n_cmp++; if (rnd_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid: got %b want 1", rnd_valid); end
        n_cmp++; if (rnd_data !== exp_first) begin n_bad++; $display("FAIL bp_keep_first: got %h want %h", rnd_data, exp_first); end
        rnd_ready = 1;
        tick();
        n_cmp++; if (rnd_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: got %b want 0", rnd_valid); end
    endtask

    task automatic test_health();
        int cnt = 0;
        bit pv = 0;
        idle_prep();
        debias_en = 0; enable = 1; test_bit = 1;
        for (int k = 0; k < 400 && m_strobes < REP; k++) begin
            tick();
            if (m_strobes == REP - 1) begin
                n_cmp++; if (health_fail !== 1'b0) begin n_bad++; $display("FAIL health_early: got %b want 0", health_fail); end
            end
        end
        n_cmp++; if (health_fail !== 1'b1) begin n_bad++; $display("FAIL health_set: got %b want 1", health_fail); end
        tick();
        repeat (70) begin tick(); if (rnd_valid === 1'b1) cnt++; end
        n_cmp++; if (cnt != 0) begin n_bad++; $display("FAIL health_block: got %0d valid cycles want 0", cnt); end
        health_clr = 1; tick(); health_clr = 0;
        n_cmp++; if (health_fail !== 1'b0) begin n_bad++; $display("FAIL health_clr: got %b want 0", health_fail); end
        cnt = 0;
        repeat (40) begin
            test_bit = 1'(m_strobes % 2);
            tick();
            if (rnd_valid === 1'b1 && !pv) cnt++;
            pv = rnd_valid;
        end
        n_cmp++; if (cnt < 1) begin n_bad++; $display("FAIL health_resume: got %0d words want >=1", cnt); end
    endtask

    task automatic test_divider_abort();
        int first = -1;
        bit pv;
        idle_prep();
        debias_en = 0; sample_div = 8'd3; rnd_ready = 0; enable = 1;
        for (int k = 0; k < WARM + 128 + 64; k++) begin
            test_bit = 1'($urandom_range(0, 1));
            tick();
            if (rnd_valid === 1'b1 && first < 0) first = k;
        end
        n_cmp++; if (first != WARM + 128) begin n_bad++; $display("FAIL div_latency: got %0d want %0d", first, WARM + 128); end
        enable = 0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (rnd_valid !== 1'b1 || rnd_data !== m_data) begin
            n_bad++; $display("FAIL abort_pending: got v=%b d=%h want v=1 d=%h", rnd_valid, rnd_data, m_data);
        end
        rnd_ready = 1; enable = 1; first = -1; pv = 1;
        for (int k = 0; k < WARM + 140 && first < 0; k++) begin
            test_bit = 1'($urandom_range(0, 1));
            tick();
            if (rnd_valid === 1'b1 && !pv) first = k;
            pv = rnd_valid;
        end
        n_cmp++; if (first != WARM + 128) begin n_bad++; $display("FAIL abort_partial_lost: got %0d want %0d", first, WARM + 128); end
        rnd_ready = 0;
        for (int k = 0; k < 200 && rnd_valid !== 1'b1; k++) begin test_bit = 1'($urandom_range(0, 1)); tick(); end
        #2 rst_n = 0;
        #1;
        n_cmp++; if ({rnd_valid, health_fail, busy} !== 3'b000 || rnd_data !== '0) begin
            n_bad++; $display("FAIL async_reset: got v=%b d=%h f=%b b=%b want all 0", rnd_valid, rnd_data, health_fail, busy);
        end
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            idle_prep();
            sample_div = 8'($urandom_range(0, 3));
            debias_en = 1'($urandom_range(0, 1));
            enable = 1;
            for (int k = 0; k < 1200; k++) begin
                test_bit   = 1'($urandom_range(0, 1));
                rnd_ready  = ($urandom_range(0, 3) != 0);
                health_clr = ($urandom_range(0, 199) == 0);
                enable     = ($urandom_range(0, 499) != 0);
                tick();
                n_cmp++;
                if (rnd_valid !== m_valid || rnd_data !== m_data || health_fail !== m_fail || busy !== m_busy) begin
                    n_bad++;
                    $display("FAIL random_model r=%0d k=%0d: got v=%b d=%h f=%b b=%b want v=%b d=%h f=%b b=%b",
                             r, k, rnd_valid, rnd_data, health_fail, busy, m_valid, m_data, m_fail, m_busy);
                end
            end
            health_clr = 0;
        end
    endtask

    initial begin
        rst_n = 0; enable = 0; debias_en = 0; sample_div = 0; test_en = 1; test_bit = 0;
        health_clr = 0; rnd_ready = 1;
        model_reset();
        test_reset();
        test_warmup();
        test_raw_packing();
        test_debias();
        test_back_to_back();
        test_health();
        test_divider_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
